// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load-data formatter: beat collection, byte alignment, sign/zero extension
//
// Sits between the memory data register path and register writeback. A load
// request names a byte offset, a size and a signedness; the unit collects one
// aligned beat (or two when the field crosses a beat boundary), extracts the
// addressed bytes, aligns them to bit 0 and extends them to DATA_W.
//
// Ports:
//   clk, reset_n                     clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready              load request handshake
//   req_addr_lo/req_size/req_signed  byte offset, size code, sign-extend select
//   mem_valid/mem_ready/mem_data     aligned memory beat handshake (little-endian)
//   out_valid/out_ready              result handshake
//   out_data/out_err                 aligned result; err = misaligned load rejected
//   busy                             unit is not idle

module load_align_unit #(
    parameter int DATA_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1,
    localparam int NB              = DATA_W / 8,
    localparam int OFF_W           = $clog2(NB)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OFF_W-1:0]  req_addr_lo,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [1:0] SZ_FULL = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // Byte count of a size code. Fits OFF_W+1 bits because NB = 2**OFF_W.
    function automatic logic [OFF_W:0] size_bytes(input logic [1:0] sz);
        logic [OFF_W:0] nb;
        case (sz)
            SZ_BYTE: nb = (OFF_W+1)'(1);
            SZ_HALF: nb = (OFF_W+1)'(2);
            SZ_WORD: nb = (OFF_W+1)'(4);
            default: nb = (OFF_W+1)'(NB);
        endcase
        return nb;
    endfunction

    // Pull the addressed field out of {hi, lo}, align it to bit 0 and extend.
    // Full-width loads have nothing above the field, so signedness is moot.
    function automatic logic [DATA_W-1:0] extract(
        input logic [DATA_W-1:0] hi,
        input logic [DATA_W-1:0] lo,
        input logic [OFF_W-1:0]  off,
        input logic [1:0]        sz,
        input logic              sgn
    );
        logic [2*DATA_W-1:0] cat;
        logic [DATA_W-1:0]   field;
        logic [DATA_W-1:0]   res;
        logic [OFF_W:0]      nb;
        logic                fill;
        cat   = {hi, lo} >> {off, 3'b000};
        field = cat[DATA_W-1:0];
        nb    = size_bytes(sz);
        case (sz)
            SZ_BYTE: fill = sgn & field[7];
            SZ_HALF: fill = sgn & field[15];
            SZ_WORD: fill = sgn & field[31];
            default: fill = 1'b0;
        endcase
        res = '0;
        for (int i = 0; i < NB; i++) begin
            res[8*i +: 8] = (i < int'(nb)) ? field[8*i +: 8] : {8{fill}};
        end
        return res;
    endfunction

    logic [1:0]        state_q,    state_d;
    logic [OFF_W-1:0]  addr_q,     addr_d;
    logic [1:0]        size_q,     size_d;
    logic              signed_q,   signed_d;
    logic              cross_q,    cross_d;
    logic [DATA_W-1:0] buf0_q,     buf0_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_err_q,  out_err_d;

    // End offset of the incoming request; past NB means the field spills into
    // the next beat. One spare bit keeps addr + nbytes from wrapping.
    logic [OFF_W+1:0] req_end;
    logic             req_cross;

    assign req_end   = (OFF_W+2)'(req_addr_lo) + (OFF_W+2)'(size_bytes(req_size));
    assign req_cross = (req_end > (OFF_W+2)'(NB));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        signed_d   = signed_q;
        cross_d    = cross_q;
        buf0_d     = buf0_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr_lo;
                    size_d   = req_size;
                    signed_d = req_signed;
                    if (req_cross && !ALLOW_MISALIGNED) begin
                        // Rejected without touching memory.
                        out_err_d  = 1'b1;
                        out_data_d = '0;
                        cross_d    = 1'b0;
                        state_d    = S_HOLD;
                    end else begin
                        cross_d = req_cross;
                        state_d = S_BEAT0;
                    end
                end
            end

            S_BEAT0: begin
                if (mem_valid) begin
                    buf0_d = mem_data;
                    if (cross_q) begin
                        state_d = S_BEAT1;
                    end else begin
                        out_data_d = extract('0, mem_data, addr_q, size_q, signed_q);
                        out_err_d  = 1'b0;
                        state_d    = S_HOLD;
                    end
                end
            end

            S_BEAT1: begin
                if (mem_valid) begin
                    out_data_d = extract(mem_data, buf0_q, addr_q, size_q, signed_q);
                    out_err_d  = 1'b0;
                    state_d    = S_HOLD;
                end
            end

            default: begin
                // HOLD: result stays put until consumed; out_data keeps its
                // value afterwards, only the error qualifier is dropped.
                if (out_ready) begin
                    out_err_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            cross_q    <= 1'b0;
            buf0_q     <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            cross_q    <= cross_d;
            buf0_q     <= buf0_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_ready = (state_q == S_BEAT0) || (state_q == S_BEAT1);
    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Parametrised load-data formatter between the memory data register path and register writeback. Accepts a load request (byte offset, size, signedness), collects one or two aligned memory beats, extracts and byte-aligns the addressed field, then zero- or sign-extends it to DATA_W. Supports loads that cross a beat boundary and has valid/ready handshakes on all three interfaces.

Parameters:
DATA_W, 32, beat and result width in bits; multiple of 8, DATA_W/8 a power of two, minimum 32
ALLOW_MISALIGNED, 1, 1 = boundary-crossing loads take two beats; 0 = misaligned loads flagged as errors
OFF_W (localparam), log2(DATA_W/8), byte-offset width

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  load request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_addr_lo  in  OFF_W  byte offset of the load within the aligned beat
req_size  in  2  01 = halfword (16b), 10 = byte (8b), 11 = word (32b), 00 = full DATA_W
req_signed  in  1  1 = sign-extend, 0 = zero-extend
mem_valid  in  1  memory beat valid
mem_ready  out  1  beat accepted when mem_valid & mem_ready
mem_data  in  DATA_W  aligned memory beat; byte 0 = bits [7:0], little-endian
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid & out_ready
out_data  out  DATA_W  aligned, extended load result
out_err  out  1  qualifies out_data; 1 = misaligned load rejected
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous, active-low: state = IDLE; out_valid = 0; out_data = 0; out_err = 0; beat-0 buffer and latched request fields cleared. Reset in any state aborts the load. Partially collected beats are discarded, and no output is produced for the aborted request.
- FSM states: IDLE, BEAT0, BEAT1, HOLD.
- IDLE: req_ready = 1. Nothing else is driven high. On accept, latch addr_lo, size, and signed. Compute nbytes from size (1/2/4/DATA_W/8).
  - If addr_lo + nbytes > DATA_W/8 (crossing) and ALLOW_MISALIGNED = 0: go to HOLD with out_err = 1 and out_data = 0. No memory beat is requested.
  - Otherwise go to BEAT0 and set cross = (addr_lo + nbytes > DATA_W/8).
- BEAT0: mem_ready = 1. On a beat, store it in buf0.
  - If cross = 1, go to BEAT1.
  - If cross = 0, compute the result from {0, beat} and go to HOLD.
- BEAT1: mem_ready = 1. On a beat, compute the result from {beat, buf0} and go to HOLD.
- Extraction: result byte i = byte (addr_lo + i) of the 2·DATA_W concatenation {hi, lo}, for i < nbytes.
  - Bits above 8·nbytes are filled with the MSB of the extracted field if signed = 1, and with 0 otherwise.
  - Size 00 ignores req_signed.
- HOLD: out_valid = 1. out_data and out_err are registered and stay stable until accepted. On out_ready, go to IDLE and clear out_valid. out_data holds its last value. out_err is cleared.
- req_ready = 0 and mem_ready = 0 outside the states listed above. mem_valid pulses in IDLE or HOLD are ignored and not buffered.
- Latency (no stalls):
  - Aligned: request accepted at cycle 0, beat at cycle 1, out_valid at cycle 2.
  - Crossing: beats at cycles 1 and 2, out_valid at cycle 3.
  - Error: out_valid at cycle 1.
- One load in flight at a time. A new request is accepted at the earliest in the cycle after the HOLD handshake.
- DATA_W = 32: size 11 and size 00 produce identical results.

Test Plan:
1. DATA_W=32. Byte load: addr_lo=3, size=10, signed=1, beat 0x80123456 -> out_data 0xFFFFFF80, out_err=0, out_valid two cycles after request accept. Same with signed=0 -> 0x00000080.
2. Halfword load: addr_lo=2, size=01, beat 0xBEEF1234 -> unsigned 0x0000BEEF, signed 0xFFFFBEEF. Word load: addr_lo=0, size=00 -> 0xBEEF1234 regardless of signed.
3. ALLOW_MISALIGNED=1. Word load: addr_lo=1, size=11, beats 0x44332211 then 0x88776655 -> 0x55443322 after exactly two mem handshakes. Halfword load: addr_lo=3, same beats -> 0x00005544.
4. ALLOW_MISALIGNED=0. Word load: addr_lo=2 -> out_valid=1 and out_err=1 the cycle after accept, out_data=0, mem_ready never asserted.
5. Backpressure: hold out_ready=0 for 3 cycles in HOLD -> out_data stable, req_ready=0, mem_ready=0, extra mem_valid pulses ignored. Release -> one output handshake, then req_ready=1.
6. Assert reset_n=0 mid-cycle while in BEAT1 -> out_valid, out_data, out_err and busy drop to 0 immediately. After release, a fresh byte load at addr_lo=0 with beat 0x000000A5 -> 0x000000A5, unaffected by the stale buf0.
